// File: rtl/mips_cpu_muldiv_if.sv
// Request/response bundle between the CPU pipeline and the multiply/divide unit.
interface mips_cpu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiplier and restoring divider share one 2*WIDTH accumulator;
// signed ops run on magnitudes and are sign-corrected in the FIX cycle.
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    mips_cpu_muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Datapath: operand magnitudes, one multiply/divide step, and sign fix-up.
    always_comb begin
        sgn   = ~bus.op[0];
        a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply: add multiplicand into upper half when LSB set, then shift right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift next dividend bit into remainder, subtract if it fits.
        // With a zero divisor the remainder ends up equal to the dividend.
        div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd_q};
        if (div_diff[WIDTH])
            div_next = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register-update logic for the IDLE/RUN/FIX sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_d   = bus.op[1];
                    neg_d   = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rneg_d  = sgn & bus.a[WIDTH-1];
                    bzero_d = (bus.b == '0);
                    acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    opnd_d  = bus.op[1] ? b_mag : a_mag;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = bzero_q ? '0 : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (WIDTH = 32).
module tb_mips_cpu_muldiv;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge (E0); operands are scrambled afterwards.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait (bounded) for done; latency counted in edges after E0.
    task automatic wait_done(input string tag, input int elapsed,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        lat = 0;
        for (int k = elapsed + 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".lo"}, bus.lo, exp_lo);
        check({tag, ".busy_low"}, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        launch(op, a, b);
        check({tag, ".busy"}, {31'b0, bus.busy}, 32'd1);
        wait_done(tag, 0, exp_hi, exp_lo);
    endtask

    initial begin
        int seen;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        repeat (2) @(negedge clk);
        check("reset.busy", {31'b0, bus.busy}, 32'd0);
        check("reset.done", {31'b0, bus.done}, 32'd0);
        check("reset.hi", bus.hi, 32'd0);
        check("reset.lo", bus.lo, 32'd0);
        rst = 1'b0;

        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, bus.done}, 32'd0);

        // Remaining ops are launched in the done cycle of the previous one.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_by0", 2'b11, 32'd7, 32'd0, 32'd7, 32'd0);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'd0);
        run_op("mult_min_x2", 2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // Start and MTLO while busy are both ignored.
        launch(2'b11, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("busy_we.lo_held", bus.lo, 32'hFFFF_FFFD);
        check("busy_we.hi_held", bus.hi, 32'h0000_0001);
        wait_done("divu_100_7", 6, 32'd2, 32'd14);

        // Asynchronous reset mid-operation.
        launch(2'b01, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", {31'b0, bus.busy}, 32'd0);
        check("abort.hi", bus.hi, 32'd0);
        check("abort.lo", bus.lo, 32'd0);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        check("abort.lo_after", bus.lo, 32'd0);

        // MTHI in IDLE.
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi.hi", bus.hi, 32'h0000_1234);
        check("mthi.lo", bus.lo, 32'd0);

        // MTHI and MTLO together.
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5A5A;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthilo.hi", bus.hi, 32'h0000_5A5A);
        check("mthilo.lo", bus.lo, 32'h0000_5A5A);

        // Start wins over simultaneous HI/LO writes.
        @(negedge clk);
        bus.op    = 2'b01;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("start_wins.hi", bus.hi, 32'h0000_5A5A);
        check("start_wins.lo", bus.lo, 32'h0000_5A5A);
        check("start_wins.busy", {31'b0, bus.busy}, 32'd1);
        wait_done("multu_6x7", 0, 32'd0, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS CPU core. It replaces the single-cycle combinational MULT/DIV paths in the ALU with an iterative shift-add multiplier and a restoring divider. The unit also accepts direct writes to HI and LO for MTHI/MTLO. The datapath uses a start/busy/done handshake so that MFHI/MFLO are stalled until `done`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request an operation; sampled only in IDLE.
- `op`, input, 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`, input, WIDTH: multiplicand or dividend; captured when `start` is accepted.
- `b`, input, WIDTH: multiplier or divisor; captured when `start` is accepted.
- `hi_we`, input, 1: write `wdata` to HI (MTHI).
- `lo_we`, input, 1: write `wdata` to LO (MTLO).
- `wdata`, input, WIDTH: data for HI/LO writes.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; HI/LO hold the new result.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - `start=1` captures `op`, `a` and `b`, and goes to RUN. An internal step counter is set to WIDTH.
  - For signed ops, the operand magnitudes are captured (two's-complement negate if the MSB is set). The result-sign flags are stored at the same time.
- **RUN**
  - Performs one iteration per cycle. The counter decrements, and the FSM goes to FIX after WIDTH iterations.
  - Multiply: shift-add over a 2×WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- **FIX**
  - Applies sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
- Multiply results:
  - MULTU: {HI, LO} = a × b (unsigned, 2×WIDTH bits).
  - MULT: {HI, LO} = |a| × |b|, negated across the full 2×WIDTH bits if sign(a) ≠ sign(b).
- Divide results:
  - DIVU: LO = a / b, HI = a % b.
  - DIV: the quotient is negated if sign(a) ≠ sign(b). The remainder takes the sign of `a`.
- Boundary cases:
  - Divide by zero (DIV or DIVU): LO = 0, HI = `a` unchanged. The latency is the same as for a normal divide.
  - DIV of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1) (wraps), HI = 0.
  - MULT with either operand at −2^(WIDTH−1) must be exact. The magnitude 2^(WIDTH−1) is treated as unsigned.
- Handshake and write rules:
  - `start` while `busy` is ignored; the operation in flight is unaffected.
  - `hi_we`/`lo_we` in IDLE write on the next edge. Both may be asserted together.
  - `hi_we`/`lo_we` while `busy` are ignored.
  - `start` and `hi_we`/`lo_we` in the same IDLE cycle: `start` wins and the writes are dropped.
- HI/LO change only on reset, a FIX cycle, or an IDLE write. They hold their value at all other times.

## Timing
- Reset state: IDLE, `busy=0`, `done=0`, `hi=0`, `lo=0`, counter 0.
- Reset during RUN or FIX aborts the operation immediately (asynchronously). No result is written.
- Cycle numbering, with `start` accepted at edge E0:
  - `busy` is 1 from E0 through edge E(WIDTH+1).
  - RUN occupies edges E1 through E(WIDTH).
  - FIX is the edge E(WIDTH+1). At that edge HI and LO update, `done` goes to 1 and `busy` goes to 0.
- Latency from the `start` edge to the cycle where the result is visible with `done=1` is WIDTH+1 edges.
- `done` is high for exactly one cycle.
- A new `start` may be accepted in the `done` cycle (back-to-back). Throughput is one operation per WIDTH+2 cycles.
- `a` and `b` need not be held after E0.
- `busy` and `done` are registered outputs; neither has a combinational path from the inputs.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=5 → after 33 edges, `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7 / 0 → lo=0, hi=7, same latency as a normal divide.
- Handshake and reset:
  - Second `start` (MULTU 2×3) at cycle 5 of DIVU 100/7 is ignored → lo=14, hi=2.
  - `lo_we`=1 with `wdata`=0xAAAA while busy is ignored.
  - In a separate operation, `rst` pulsed at cycle 10 → busy=0, done never pulses, hi=lo=0.
  - Then MTHI 0x1234 → hi=0x1234 next cycle.
